// File: rtl/sio_pkg.sv
// sio_pkg: shared types and constants for the serial I/O chain controller.
//   sio_state_t  - frame sequencer states
//   sclk_phase_t - level of the serial clock driven to the board registers
//   FRAME_W      - bits per frame (LED and button registers are both 8 bits)
package sio_pkg;

  localparam int FRAME_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } sio_state_t;

  typedef enum logic {
    SCLK_LO = 1'b0,
    SCLK_HI = 1'b1
  } sclk_phase_t;

endpackage

// File: rtl/sio_bit_timer.sv
// sio_bit_timer: CLK_DIV-cycle phase timer shared by the SHIFT_LO, SHIFT_HI
// and LATCH phases of a frame.
//   clk, rst : clock and synchronous active-high reset
//   i_load   : pulse on the edge that enters a new phase
//   o_done   : high on the last cycle of the phase
//   o_near   : high on the second-to-last cycle of the phase
// A phase entered through i_load lasts exactly CLK_DIV cycles (CLK_DIV >= 2).
module sio_bit_timer #(
  parameter int CLK_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_done,
  output logic o_near
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Down-counter: reload on phase entry, stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LAST;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == '0);
  assign o_near = (r_cnt == CW'(1));

endmodule

// File: rtl/sio_ctrl.sv
// sio_ctrl: sequencer and arbiter for the shared serial chain of an 8-bit
// LED shift/latch register and an 8-bit button parallel-load register.
//   clk, rst            : clock, synchronous active-high reset
//   wr_req/wr_data/wr_ack : CPU LED write handshake (ack is a 1-cycle pulse)
//   rd_req/rd_ack       : CPU button read handshake (ack is a 1-cycle pulse)
//   btn_data, btn_event : last sampled button byte, pulse when it changed
//   busy                : frame in progress (state != IDLE)
//   sclk, sdata, sdata_pl, sdatain : board serial pins
// One frame serves every request present in LOAD; with no request pending,
// an auto-refresh frame runs after REFRESH idle cycles (0 disables it).
module sio_ctrl
  import sio_pkg::*;
#(
  parameter int CLK_DIV = 1024,
  parameter int REFRESH = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic [7:0] btn_data,
  output logic       btn_event,
  output logic       busy,
  output logic       sclk,
  output logic       sdata,
  output logic       sdata_pl,
  input  logic       sdatain
);

  localparam int                     BW       = $clog2(FRAME_W);
  localparam logic [BW-1:0]          LAST_BIT = BW'(FRAME_W - 1);
  localparam int                     RW       = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [RW-1:0]          REF_LAST = (REFRESH > 0) ? RW'(REFRESH - 1) : '0;

  sio_state_t          r_state;
  sclk_phase_t         r_sclk;
  logic [1:0]          r_served;   // {write, read} served by the current frame
  logic [FRAME_W-1:0]  r_shadow;
  logic [FRAME_W-1:0]  r_in_shift;
  logic [BW-1:0]       r_bit;
  logic [RW-1:0]       r_ref_cnt;
  logic                r_sdata;
  logic                r_sdata_pl;
  logic                r_busy;
  logic                r_wr_ack;
  logic                r_rd_ack;
  logic [FRAME_W-1:0]  r_btn_data;
  logic                r_btn_event;

  logic                w_tmr_load;
  logic                w_tmr_done;
  logic                w_tmr_near;
  logic                w_ref_due;
  logic [BW-1:0]       w_next_bit;

  // The timer restarts on every phase entry: LOAD->SHIFT_LO, LO->HI, HI->LO/LATCH.
  assign w_tmr_load = (r_state == ST_LOAD) ||
                      (((r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI)) && w_tmr_done);
  assign w_ref_due  = (REFRESH != 0) && (r_ref_cnt == REF_LAST);
  assign w_next_bit = r_bit + BW'(1);

  sio_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tmr_load),
    .o_done (w_tmr_done),
    .o_near (w_tmr_near)
  );

  // Frame FSM; every output is a register set on the edge entering its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sclk      <= SCLK_LO;
      r_served    <= 2'b00;
      r_shadow    <= '0;
      r_in_shift  <= '0;
      r_bit       <= '0;
      r_ref_cnt   <= '0;
      r_sdata     <= 1'b0;
      r_sdata_pl  <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_btn_data  <= '0;
      r_btn_event <= 1'b0;
    end else begin
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_btn_event <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // CPU requests and refresh share the same path; the served set is
          // taken in LOAD, so a refresh frame carries no ack.
          if (wr_req || rd_req || w_ref_due) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_ref_cnt <= r_ref_cnt + RW'(1);
          end
        end
        ST_LOAD: begin
          r_served <= {wr_req, rd_req};
          if (wr_req) begin
            r_shadow <= wr_data;
            r_sdata  <= wr_data[0];
          end else begin
            r_sdata  <= r_shadow[0];
          end
          r_sdata_pl <= 1'b1;
          r_bit      <= '0;
          r_ref_cnt  <= '0;
          r_sclk     <= SCLK_LO;
          r_state    <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          // Button bit is taken one cycle before the sclk rise shifts it out.
          if (w_tmr_done) begin
            r_in_shift[r_bit] <= sdatain;
            r_sclk            <= SCLK_HI;
            r_state           <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (w_tmr_done) begin
            r_sclk <= SCLK_LO;
            if (r_bit == LAST_BIT) begin
              r_sdata_pl <= 1'b0;
              r_state    <= ST_LATCH;
            end else begin
              r_bit   <= w_next_bit;
              r_sdata <= r_shadow[w_next_bit];
              r_state <= ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          // Results are registered on the near edge so they are visible
          // during the last LATCH cycle.
          if (w_tmr_near) begin
            r_btn_data  <= r_in_shift;
            r_btn_event <= (r_in_shift != r_btn_data);
            r_wr_ack    <= r_served[1];
            r_rd_ack    <= r_served[0];
          end
          if (w_tmr_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy     <= 1'b0;
          r_sclk     <= SCLK_LO;
          r_sdata_pl <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_ack    = r_wr_ack;
  assign rd_ack    = r_rd_ack;
  assign btn_data  = r_btn_data;
  assign btn_event = r_btn_event;
  assign busy      = r_busy;
  assign sclk      = r_sclk;
  assign sdata     = r_sdata;
  assign sdata_pl  = r_sdata_pl;

endmodule

// File: tb/tb_sio_ctrl.sv
// Bench for sio_ctrl: instance A (CLK_DIV=4, REFRESH=0) runs a vector table
// plus the queued-read and mid-frame reset sequences; instance B
// (CLK_DIV=4, REFRESH=16) runs the auto-refresh sequence. Each instance has
// a small behavioural model of the board button register feeding sdatain.
module tb_sio_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_wr_req, a_rd_req, a_wr_ack, a_rd_ack, a_btn_event, a_busy;
  logic       a_sclk, a_sdata, a_sdata_pl, a_sdatain;
  logic [7:0] a_wr_data, a_btn_data, a_btn;
  logic [7:0] a_sr = 8'h00;
  logic       a_prev_sclk = 1'b0;

  logic       b_wr_req, b_rd_req, b_wr_ack, b_rd_ack, b_btn_event, b_busy;
  logic       b_sclk, b_sdata, b_sdata_pl, b_sdatain;
  logic [7:0] b_wr_data, b_btn_data, b_btn;
  logic [7:0] b_sr = 8'h00;
  logic       b_prev_sclk = 1'b0;

  sio_ctrl #(.CLK_DIV(4), .REFRESH(0)) u_a (
    .clk(clk), .rst(rst), .wr_req(a_wr_req), .wr_data(a_wr_data), .wr_ack(a_wr_ack),
    .rd_req(a_rd_req), .rd_ack(a_rd_ack), .btn_data(a_btn_data), .btn_event(a_btn_event),
    .busy(a_busy), .sclk(a_sclk), .sdata(a_sdata), .sdata_pl(a_sdata_pl), .sdatain(a_sdatain)
  );

  sio_ctrl #(.CLK_DIV(4), .REFRESH(16)) u_b (
    .clk(clk), .rst(rst), .wr_req(b_wr_req), .wr_data(b_wr_data), .wr_ack(b_wr_ack),
    .rd_req(b_rd_req), .rd_ack(b_rd_ack), .btn_data(b_btn_data), .btn_event(b_btn_event),
    .busy(b_busy), .sclk(b_sclk), .sdata(b_sdata), .sdata_pl(b_sdata_pl), .sdatain(b_sdatain)
  );

  // Button register models: parallel load while sdata_pl low, shift right on sclk rise.
  always @(posedge clk) begin
    a_prev_sclk <= a_sclk;
    if (!a_sdata_pl) a_sr <= a_btn;
    else if (a_sclk && !a_prev_sclk) a_sr <= {1'b0, a_sr[7:1]};
  end
  assign a_sdatain = a_sr[0];

  always @(posedge clk) begin
    b_prev_sclk <= b_sclk;
    if (!b_sdata_pl) b_sr <= b_btn;
    else if (b_sclk && !b_prev_sclk) b_sr <= {1'b0, b_sr[7:1]};
  end
  assign b_sdatain = b_sr[0];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] btn;
    logic       exp_wack;
    logic       exp_rack;
    logic [7:0] exp_btn;
    logic       exp_evt;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs [6];

  // One frame on instance A: latency, acks, button result, LED bits, pulse shapes.
  task automatic run_frame(input int idx, input vec_t v);
    int         n = 0;
    int         rises = 0;
    int         pl_low = 0;
    int         busy_rises = 0;
    logic [7:0] led = 8'h00;
    logic       got = 1'b0;
    logic       p_sclk;
    logic       p_busy;
    @(negedge clk);
    a_btn = v.btn; a_wr_data = v.wdata; a_wr_req = v.wr; a_rd_req = v.rd;
    p_sclk = a_sclk; p_busy = a_busy;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (a_sclk && !p_sclk) begin
        if (rises < 8) led[rises] = a_sdata;
        rises++;
      end
      if (a_busy && !p_busy) busy_rises++;
      if (a_busy && !a_sdata_pl && rises > 0) pl_low++;
      p_sclk = a_sclk; p_busy = a_busy;
      if (a_wr_ack || a_rd_ack) got = 1'b1;
    end
    check($sformatf("v%0d_ack_seen", idx), got, 1);
    check($sformatf("v%0d_latency", idx), n, 69);
    check($sformatf("v%0d_wr_ack", idx), a_wr_ack, v.exp_wack);
    check($sformatf("v%0d_rd_ack", idx), a_rd_ack, v.exp_rack);
    check($sformatf("v%0d_btn_data", idx), a_btn_data, v.exp_btn);
    check($sformatf("v%0d_btn_event", idx), a_btn_event, v.exp_evt);
    check($sformatf("v%0d_led", idx), led, v.exp_led);
    check($sformatf("v%0d_sclk_rises", idx), rises, 8);
    check($sformatf("v%0d_latch_len", idx), pl_low, 4);
    check($sformatf("v%0d_frames", idx), busy_rises, 1);
    a_wr_req = 1'b0; a_rd_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_ack_width", idx), {a_wr_ack, a_rd_ack}, 0);
    check($sformatf("v%0d_evt_width", idx), a_btn_event, 0);
    check($sformatf("v%0d_idle", idx), a_busy, 0);
  endtask

  initial begin
    int         n;
    int         wr_at, rd_at, load_at, evt_at, acks, rises;
    logic       p_busy, p_sclk, idle70, rd_at_wr, wr_at_rd;
    logic [7:0] led;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 8'h5A, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 8'h11, 8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF};

    rst = 1'b1;
    a_wr_req = 1'b0; a_rd_req = 1'b0; a_wr_data = 8'h00; a_btn = 8'h00;
    b_wr_req = 1'b0; b_rd_req = 1'b0; b_wr_data = 8'h00; b_btn = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outputs", {a_wr_ack, a_rd_ack, a_btn_event, a_busy, a_sclk, a_sdata, a_sdata_pl}, 0);
    check("rst_btn_data", a_btn_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle", a_busy, 0);

    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // Read raised 10 cycles into a write frame waits for a second frame.
    @(negedge clk);
    a_wr_data = 8'hC3; a_btn = 8'h18; a_wr_req = 1'b1;
    n = 0; wr_at = -1; rd_at = -1; load_at = -1; idle70 = 1'b1;
    rd_at_wr = 1'b1; wr_at_rd = 1'b1; p_busy = a_busy;
    while (rd_at < 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (a_busy && !p_busy) load_at = n;
      p_busy = a_busy;
      if (n == 70) idle70 = a_busy;
      if (a_wr_ack) begin wr_at = n; rd_at_wr = a_rd_ack; a_wr_req = 1'b0; end
      if (a_rd_ack) begin rd_at = n; wr_at_rd = a_wr_ack; end
      if (n == 10) a_rd_req = 1'b1;
    end
    check("q_wr_ack_at", wr_at, 69);
    check("q_no_rd_in_wr", rd_at_wr, 0);
    check("q_idle_gap", idle70, 0);
    check("q_second_load", load_at, 71);
    check("q_rd_ack_at", rd_at, 139);
    check("q_no_wr_in_rd", wr_at_rd, 0);
    check("q_btn_data", a_btn_data, 8'h18);
    a_rd_req = 1'b0;
    @(negedge clk);

    // Reset during SHIFT_HI of bit 3 aborts the frame.
    a_wr_data = 8'hFF; a_btn = 8'h66; a_wr_req = 1'b1;
    n = 0; rises = 0; p_sclk = a_sclk;
    while (rises < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (a_sclk && !p_sclk) rises++;
      p_sclk = a_sclk;
    end
    check("abort_reached_bit3", rises, 4);
    rst = 1'b1; a_wr_req = 1'b0;
    @(negedge clk);
    check("abort_outputs", {a_wr_ack, a_rd_ack, a_btn_event, a_busy, a_sclk, a_sdata, a_sdata_pl}, 0);
    check("abort_btn_data", a_btn_data, 0);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_wr_ack || a_rd_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_stays_idle", a_busy, 0);

    // Auto-refresh on instance B.
    rst = 1'b1; b_btn = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0; b_wr_data = 8'h3C; b_wr_req = 1'b1;
    n = 0;
    while (!(b_wr_ack || b_rd_ack) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ref_wr_latency", n, 69);
    check("ref_wr_ack", b_wr_ack, 1);
    check("ref_wr_evt", b_btn_event, 0);
    b_wr_req = 1'b0; b_btn = 8'h81;
    n = 0; load_at = -1; evt_at = -1; acks = 0; rises = 0; led = 8'h00;
    p_busy = b_busy; p_sclk = b_sclk;
    while (evt_at < 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (b_busy && !p_busy && load_at < 0) load_at = n;
      if (b_sclk && !p_sclk) begin
        if (rises < 8) led[rises] = b_sdata;
        rises++;
      end
      p_busy = b_busy; p_sclk = b_sclk;
      if (b_wr_ack || b_rd_ack) acks++;
      if (b_btn_event) evt_at = n;
    end
    check("ref_load_at", load_at, 17);
    check("ref_evt_at", evt_at, 85);
    check("ref_btn_data", b_btn_data, 8'h81);
    check("ref_no_ack", acks, 0);
    check("ref_led", led, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
